// File: rtl/alu_pkg.sv
// Shared ALU op encoding, opcode/funct7 constants and decode helpers
// for the ALU-op decode stage.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL, ALU_MULH,
        ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        alu_op_t alu_op;
        logic    illegal;
    } dec_t;

    // funct3 -> op for the funct7=0000000 row of OP (and non-shift OP-IMM)
    function automatic alu_op_t base_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_t muldiv_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode_stage_decode_comb.sv
// Pure combinational opcode/funct3/funct7 -> {alu_op, illegal} decode.
// Illegal encodings always report ALU_ADD.
module alu_op_decode_comb
    import alu_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    always_comb begin
        dec = '{alu_op: ALU_ADD, illegal: 1'b0};
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: dec.alu_op = base_op(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
                        else                       dec.illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (EN_MEXT) dec.alu_op  = muldiv_op(funct3);
                        else         dec.illegal = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            // funct7 only matters for the shift immediates; no SUBI exists
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) dec.alu_op  = ALU_SLL;
                    else                   dec.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE)     dec.alu_op  = ALU_SRL;
                    else if (funct7 == F7_ALT) dec.alu_op  = ALU_SRA;
                    else                       dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = base_op(funct3);
                end
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_JAL: dec.alu_op = ALU_ADD;
            OPC_BRANCH: dec.alu_op  = ALU_SUB;
            OPC_LUI:    dec.alu_op  = ALU_PASSB;
            default:    dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_decode_stage.sv
// Registered ALU-op decode stage: decode, main + skid entry registers with
// valid/ready handshake and flush, and a saturating illegal-entry counter.
module alu_op_decode_stage
    import alu_pkg::*;
#(
    parameter bit          EN_MEXT = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFlush,
    input  logic             iValid,
    output logic             oReady,
    input  logic [6:0]       iOpcode,
    input  logic [2:0]       iFunct3,
    input  logic [6:0]       iFunct7,
    output logic             oValid,
    input  logic             iReady,
    output alu_op_t          oAluOp,
    output logic             oIllegal,
    output logic [CNT_W-1:0] oIllegalCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam dec_t             DEC_RST = '{alu_op: ALU_ADD, illegal: 1'b0};

    dec_t             dec, main_q, skid_q;
    logic             main_vld, skid_vld, accept;
    logic [CNT_W-1:0] ill_cnt;

    alu_op_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
        .opcode (iOpcode),
        .funct3 (iFunct3),
        .funct7 (iFunct7),
        .dec    (dec)
    );

    // Ready depends only on registered skid state, never on iReady
    assign oReady = ~skid_vld & ~iRst;
    assign accept = iValid & oReady;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= DEC_RST;
            skid_q   <= DEC_RST;
            ill_cnt  <= '0;
        end else if (iFlush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (skid_vld) begin
                // oReady is low here, so nothing new arrives this cycle
                if (iReady) begin
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                end
            end else if (!main_vld || iReady) begin
                main_vld <= accept;
                if (accept) main_q <= dec;
            end else if (accept) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end
            if (accept && dec.illegal && ill_cnt != CNT_MAX)
                ill_cnt <= ill_cnt + CNT_ONE;
        end
    end

    assign oValid        = main_vld;
    assign oAluOp        = main_q.alu_op;
    assign oIllegal      = main_q.illegal;
    assign oIllegalCount = ill_cnt;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Directed bench: DUT a (M-ext on, 16-bit count) and DUT b (M-ext off,
// 2-bit count) share stimulus; expectations are hand-written per vector.
module tb_alu_op_decode_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, in_vld, rdy;
    logic [6:0] opc, f7;
    logic [2:0] f3;

    logic a_ordy, a_vld, a_ill, b_ordy, b_vld, b_ill;
    alu_op_t a_op, b_op;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int checks = 0, errors = 0;
    int exp_cnt_a = 0, exp_cnt_b = 0;

    alu_op_t base_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_t md_tab   [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    alu_op_decode_stage #(.EN_MEXT(1'b1), .CNT_W(16)) dut_a (
        .iClk(clk), .iRst(rst), .iFlush(flush), .iValid(in_vld), .oReady(a_ordy),
        .iOpcode(opc), .iFunct3(f3), .iFunct7(f7), .oValid(a_vld), .iReady(rdy),
        .oAluOp(a_op), .oIllegal(a_ill), .oIllegalCount(a_cnt)
    );

    alu_op_decode_stage #(.EN_MEXT(1'b0), .CNT_W(2)) dut_b (
        .iClk(clk), .iRst(rst), .iFlush(flush), .iValid(in_vld), .oReady(b_ordy),
        .iOpcode(opc), .iFunct3(f3), .iFunct7(f7), .oValid(b_vld), .iReady(rdy),
        .oAluOp(b_op), .oIllegal(b_ill), .oIllegalCount(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f, input logic [6:0] s7);
        in_vld = v; opc = o; f3 = f; f7 = s7;
    endtask

    // One entry through an idle stage with iReady=1; checked one cycle later
    task automatic xfer(input string tag, input logic [6:0] o, input logic [2:0] f, input logic [6:0] s7,
                        input alu_op_t ea, input bit ia, input alu_op_t eb, input bit ib);
        @(negedge clk);
        rdy = 1'b1;
        drive(1'b1, o, f, s7);
        @(negedge clk);
        in_vld = 1'b0;
        if (ia) exp_cnt_a++;
        if (ib && exp_cnt_b < 3) exp_cnt_b++;
        chk({tag, ".a_vld"}, a_vld, 1);
        chk({tag, ".a_op"},  a_op,  ea);
        chk({tag, ".a_ill"}, a_ill, ia);
        chk({tag, ".b_vld"}, b_vld, 1);
        chk({tag, ".b_op"},  b_op,  eb);
        chk({tag, ".b_ill"}, b_ill, ib);
        chk({tag, ".a_cnt"}, a_cnt, exp_cnt_a);
        chk({tag, ".b_cnt"}, b_cnt, exp_cnt_b);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".a_ordy"}, a_ordy, 0);
        chk({tag, ".a_vld"},  a_vld,  0);
        chk({tag, ".a_op"},   a_op,   ALU_ADD);
        chk({tag, ".a_ill"},  a_ill,  0);
        chk({tag, ".a_cnt"},  a_cnt,  0);
        chk({tag, ".b_vld"},  b_vld,  0);
        chk({tag, ".b_cnt"},  b_cnt,  0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rdy = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;

        // basic decode, first illegal bumps count 0 -> 1
        xfer("op_sub",  OPC_OP,     3'b000, F7_ALT, ALU_SUB, 0, ALU_SUB, 0);
        xfer("imm_sra", OPC_OP_IMM, 3'b101, F7_ALT, ALU_SRA, 0, ALU_SRA, 0);
        xfer("imm_sll_alt", OPC_OP_IMM, 3'b001, F7_ALT, ALU_ADD, 1, ALU_ADD, 1);
        chk("cnt_first", a_cnt, 1);
        xfer("op_div",  OPC_OP,     3'b100, F7_MULDIV, ALU_DIV, 0, ALU_ADD, 1);

        for (int i = 0; i < 8; i++)
            xfer("op_base", OPC_OP, 3'(i), F7_BASE, base_tab[i], 0, base_tab[i], 0);
        for (int i = 0; i < 8; i++)
            xfer("op_md", OPC_OP, 3'(i), F7_MULDIV, md_tab[i], 0, ALU_ADD, 1);
        xfer("op_sra",     OPC_OP, 3'b101, F7_ALT,     ALU_SRA, 0, ALU_SRA, 0);
        xfer("op_alt_bad", OPC_OP, 3'b001, F7_ALT,     ALU_ADD, 1, ALU_ADD, 1);
        xfer("op_f7_bad",  OPC_OP, 3'b000, 7'b0000010, ALU_ADD, 1, ALU_ADD, 1);
        xfer("imm_nosubi", OPC_OP_IMM, 3'b000, F7_ALT,     ALU_ADD,  0, ALU_ADD,  0);
        xfer("imm_slt",    OPC_OP_IMM, 3'b010, 7'b1111111, ALU_SLT,  0, ALU_SLT,  0);
        xfer("imm_sltu",   OPC_OP_IMM, 3'b011, F7_BASE,    ALU_SLTU, 0, ALU_SLTU, 0);
        xfer("imm_xor",    OPC_OP_IMM, 3'b100, F7_MULDIV,  ALU_XOR,  0, ALU_XOR,  0);
        xfer("imm_or",     OPC_OP_IMM, 3'b110, F7_BASE,    ALU_OR,   0, ALU_OR,   0);
        xfer("imm_and",    OPC_OP_IMM, 3'b111, F7_BASE,    ALU_AND,  0, ALU_AND,  0);
        xfer("imm_srl",    OPC_OP_IMM, 3'b101, F7_BASE,    ALU_SRL,  0, ALU_SRL,  0);
        xfer("imm_sll",    OPC_OP_IMM, 3'b001, F7_BASE,    ALU_SLL,  0, ALU_SLL,  0);
        xfer("imm_sr_bad", OPC_OP_IMM, 3'b101, F7_MULDIV,  ALU_ADD,  1, ALU_ADD,  1);
        xfer("load",   OPC_LOAD,   3'b010, 7'h55, ALU_ADD,   0, ALU_ADD,   0);
        xfer("store",  OPC_STORE,  3'b010, 7'h20, ALU_ADD,   0, ALU_ADD,   0);
        xfer("jalr",   OPC_JALR,   3'b000, 7'h00, ALU_ADD,   0, ALU_ADD,   0);
        xfer("auipc",  OPC_AUIPC,  3'b111, 7'h7f, ALU_ADD,   0, ALU_ADD,   0);
        xfer("jal",    OPC_JAL,    3'b011, 7'h01, ALU_ADD,   0, ALU_ADD,   0);
        xfer("branch", OPC_BRANCH, 3'b001, 7'h00, ALU_SUB,   0, ALU_SUB,   0);
        xfer("lui",    OPC_LUI,    3'b000, 7'h3c, ALU_PASSB, 0, ALU_PASSB, 0);
        xfer("system", 7'b1110011, 3'b000, 7'h00, ALU_ADD,   1, ALU_ADD,   1);
        xfer("zero",   7'b0000000, 3'b000, 7'h00, ALU_ADD,   1, ALU_ADD,   1);
        chk("b_sat_table", b_cnt, 3);

        // stall stream: A in main, B in skid, C held upstream
        @(negedge clk); rdy = 1'b0; drive(1'b1, OPC_OP, 3'b100, F7_BASE);
        @(negedge clk);
        chk("s_a_vld", a_vld, 1); chk("s_a_op", a_op, ALU_XOR); chk("s_rdy1", a_ordy, 1);
        drive(1'b1, OPC_OP, 3'b110, F7_BASE);
        @(negedge clk);
        chk("s_hold_a", a_op, ALU_XOR); chk("s_rdy0", a_ordy, 0);
        drive(1'b1, OPC_OP, 3'b111, F7_BASE);
        @(negedge clk);
        chk("s_hold_a2", a_op, ALU_XOR); chk("s_vld2", a_vld, 1); chk("s_rdy0b", a_ordy, 0);
        rdy = 1'b1;
        @(negedge clk);
        chk("s_b_vld", a_vld, 1); chk("s_b_op", a_op, ALU_OR); chk("s_b_rdy", a_ordy, 1);
        @(negedge clk);
        chk("s_c_vld", a_vld, 1); chk("s_c_op", a_op, ALU_AND); chk("s_c_bop", b_op, ALU_AND);
        in_vld = 1'b0;
        @(negedge clk);
        chk("s_empty", a_vld, 0);

        // flush with main+skid full and an illegal entry presented
        @(negedge clk); rdy = 1'b0; drive(1'b1, OPC_OP, 3'b000, F7_ALT);
        @(negedge clk); drive(1'b1, OPC_LUI, 3'b000, 7'h00);
        @(negedge clk);
        chk("f_full_rdy", a_ordy, 0); chk("f_full_vld", a_vld, 1);
        drive(1'b1, 7'b1111111, 3'b000, 7'h00); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_vld = 1'b0;
        chk("f_vld", a_vld, 0); chk("f_rdy", a_ordy, 1);
        chk("f_cnt_a", a_cnt, exp_cnt_a); chk("f_cnt_b", b_cnt, exp_cnt_b);
        // flush while ready: same-cycle input must be neither accepted nor counted
        @(negedge clk); rdy = 1'b1; drive(1'b1, 7'b1111111, 3'b000, 7'h00); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_vld = 1'b0;
        chk("f2_vld", a_vld, 0); chk("f2_cnt_a", a_cnt, exp_cnt_a);
        xfer("post_flush", OPC_OP, 3'b101, F7_BASE, ALU_SRL, 0, ALU_SRL, 0);

        // reset mid-stream with main+skid occupied
        @(negedge clk); rdy = 1'b0; drive(1'b1, OPC_OP, 3'b000, F7_ALT);
        @(negedge clk); drive(1'b1, 7'b1111111, 3'b000, 7'h00);
        @(negedge clk);
        chk("r_pre_op", a_op, ALU_SUB);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        rst = 1'b0; in_vld = 1'b0;
        exp_cnt_a = 0; exp_cnt_b = 0;

        // saturation of the 2-bit counter from a fresh reset
        for (int i = 0; i < 5; i++)
            xfer("sat", OPC_OP, 3'(i), F7_ALT + 7'd1, ALU_ADD, 1, ALU_ADD, 1);
        chk("sat_b", b_cnt, 3);
        chk("sat_a", a_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
